// File: rtl/integrator_pkg.sv
// Shared definitions for the integrator arbiter and the integrator core
// instantiations that sit behind it.
package integrator_pkg;

  // Default datapath widths; core instantiations use the same values.
  localparam int DEF_IN_W  = 8;
  localparam int DEF_ACC_W = 16;

  // Arbiter transaction states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/integrator_arbiter_rr.sv
// Combinational round-robin picker. It searches upward from the requester
// after last_grant and wraps around. The last_grant register is owned by
// the parent block.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_grant
);

  // Take the first requesting index after last_grant, modulo N.
  always_comb begin
    logic [IDW-1:0] idx_v;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx_v     = '0;
    for (int off = 1; off <= N; off++) begin
      idx_v = IDW'((int'(last_grant) + off) % N);
      if (en && !any_grant && req[idx_v]) begin
        grant_idx = idx_v;
        any_grant = 1'b1;
      end else begin
        any_grant = any_grant;
      end
    end
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/integrator_arbiter.sv
// Shares one integrator_core between N_REQ sample producers. Grants are
// round-robin. The block issues a single strobe per sample and returns
// the core result tagged with the requester id. It also keeps a sticky
// overflow bit for each requester.
module integrator_arbiter
  import integrator_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int IN_W  = DEF_IN_W,
  parameter  int ACC_W = DEF_ACC_W,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*IN_W-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    core_enable,
  output logic                    core_strobe,
  output logic [IN_W-1:0]         core_sample,
  input  logic signed [ACC_W-1:0] core_acc,
  input  logic                    core_ovf,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic signed [ACC_W-1:0] res_acc,
  output logic                    res_ovf,
  output logic [N_REQ-1:0]        ovf_sticky,
  input  logic [N_REQ-1:0]        ovf_clr,
  output logic                    busy
);

  arb_state_t              state_r;
  arb_state_t              state_nxt_s;
  logic [ID_W-1:0]         last_grant_r;
  logic [ID_W-1:0]         cur_id_r;
  logic [IN_W-1:0]         core_sample_r;
  logic                    res_valid_r;
  logic [ID_W-1:0]         res_id_r;
  logic signed [ACC_W-1:0] res_acc_r;
  logic                    res_ovf_r;
  logic [N_REQ-1:0]        ovf_sticky_r;

  logic                    grant_phase_s;
  logic [N_REQ-1:0]        grant_s;
  logic [ID_W-1:0]         grant_idx_s;
  logic                    any_grant_s;
  logic [IN_W-1:0]         granted_data_s;
  logic [N_REQ-1:0]        sticky_set_s;

  // Grants are possible only in IDLE or CAPTURE, while enabled and out of reset.
  always_comb begin
    grant_phase_s = 1'b0;
    if (enable && !rst && (state_r == ST_IDLE || state_r == ST_CAPTURE)) begin
      grant_phase_s = 1'b1;
    end else begin
      grant_phase_s = 1'b0;
    end
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .en         (grant_phase_s),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s),
    .any_grant  (any_grant_s)
  );

  assign granted_data_s = req_data[int'(grant_idx_s)*IN_W +: IN_W];

  // Next-state selection for the issue/capture handshake with the core.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_grant_s) state_nxt_s = ST_ISSUE;
        else             state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        state_nxt_s = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (any_grant_s) state_nxt_s = ST_ISSUE;
        else             state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register. Reset drops any in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // On a grant, latch the winner's sample and id and move the rotation pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r  <= ID_W'(N_REQ - 1);
      cur_id_r      <= '0;
      core_sample_r <= '0;
    end else if (any_grant_s) begin
      last_grant_r  <= grant_idx_s;
      cur_id_r      <= grant_idx_s;
      core_sample_r <= granted_data_s;
    end else begin
      last_grant_r  <= last_grant_r;
      cur_id_r      <= cur_id_r;
      core_sample_r <= core_sample_r;
    end
  end

  // Register the core result in CAPTURE and present it as a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_id_r    <= '0;
      res_acc_r   <= '0;
      res_ovf_r   <= 1'b0;
    end else if (state_r == ST_CAPTURE) begin
      res_valid_r <= 1'b1;
      res_id_r    <= cur_id_r;
      res_acc_r   <= core_acc;
      res_ovf_r   <= core_ovf;
    end else begin
      res_valid_r <= 1'b0;
      res_id_r    <= res_id_r;
      res_acc_r   <= res_acc_r;
      res_ovf_r   <= res_ovf_r;
    end
  end

  // Decode which sticky bit an overflowing result should set.
  always_comb begin
    sticky_set_s = '0;
    if (res_valid_r && res_ovf_r) begin
      sticky_set_s[res_id_r] = 1'b1;
    end else begin
      sticky_set_s = '0;
    end
  end

  // Sticky overflow per requester. A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) ovf_sticky_r <= '0;
    else     ovf_sticky_r <= (ovf_sticky_r & ~ovf_clr) | sticky_set_s;
  end

  assign busy        = (state_r == ST_ISSUE) || (state_r == ST_CAPTURE);
  assign core_strobe = (state_r == ST_ISSUE);
  assign core_enable = enable | busy;
  assign core_sample = core_sample_r;
  assign req_ready   = grant_s;
  assign res_valid   = res_valid_r;
  assign res_id      = res_id_r;
  assign res_acc     = res_acc_r;
  assign res_ovf     = res_ovf_r;
  assign ovf_sticky  = ovf_sticky_r;

endmodule
